// File: rtl/router_merge.sv
// 4-to-1 merging router: one-entry buffer per source port, round-robin
// arbitration onto a single output register tagged with the source index.
module router_merge #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] din1,
  input  logic [DATA_WIDTH-1:0] din2,
  input  logic [DATA_WIDTH-1:0] din3,
  input  logic                  din_en0,
  input  logic                  din_en1,
  input  logic                  din_en2,
  input  logic                  din_en3,
  output logic                  din_rdy0,
  output logic                  din_rdy1,
  output logic                  din_rdy2,
  output logic                  din_rdy3,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [1:0]            dout_addr,
  output logic                  dout_valid,
  input  logic                  dout_ready
);

  localparam int unsigned NUM_PORTS = 4;

  logic [DATA_WIDTH-1:0] buf_data [NUM_PORTS];
  logic [NUM_PORTS-1:0]  buf_empty;
  logic [1:0]            last_grant;

  logic [DATA_WIDTH-1:0] din_c [NUM_PORTS];
  logic [NUM_PORTS-1:0]  din_en_c;
  logic                  load_ok_c;
  logic                  grant_vld_c;
  logic [1:0]            grant_idx_c;
  logic [1:0]            probe_c;

  // Ready is the registered empty flag of each port buffer.
  assign din_rdy0 = buf_empty[0];
  assign din_rdy1 = buf_empty[1];
  assign din_rdy2 = buf_empty[2];
  assign din_rdy3 = buf_empty[3];

  // Gather ports and pick the first full buffer after the last grant.
  always_comb begin
    din_c[0]    = din0;
    din_c[1]    = din1;
    din_c[2]    = din2;
    din_c[3]    = din3;
    din_en_c    = {din_en3, din_en2, din_en1, din_en0};
    load_ok_c   = !dout_valid || dout_ready;
    grant_vld_c = 1'b0;
    grant_idx_c = 2'd0;
    probe_c     = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      probe_c = last_grant + 2'(k);
      if (!grant_vld_c && !buf_empty[probe_c]) begin
        grant_vld_c = 1'b1;
        grant_idx_c = probe_c;
      end
    end
  end

  // Fill and grant never target the same buffer in one cycle: fill needs
  // an empty buffer, grant needs a full one.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buf_empty  <= '1;
      last_grant <= 2'd3;
      dout       <= '0;
      dout_addr  <= 2'd0;
      dout_valid <= 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        buf_data[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (buf_empty[p] && din_en_c[p]) begin
          buf_empty[p] <= 1'b0;
          buf_data[p]  <= din_c[p];
        end
      end
      if (load_ok_c) begin
        if (grant_vld_c) begin
          dout                   <= buf_data[grant_idx_c];
          dout_addr              <= grant_idx_c;
          dout_valid             <= 1'b1;
          buf_empty[grant_idx_c] <= 1'b1;
          last_grant             <= grant_idx_c;
        end else begin
          dout_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_router_merge.sv
// Directed self-checking bench for router_merge.
module tb_router_merge;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] din0, din1, din2, din3;
  logic        din_en0, din_en1, din_en2, din_en3;
  logic        din_rdy0, din_rdy1, din_rdy2, din_rdy3;
  logic [31:0] dout;
  logic [1:0]  dout_addr;
  logic        dout_valid;
  logic        dout_ready;
  logic [3:0]  rdy;

  int errors = 0;
  int checks = 0;

  assign rdy = {din_rdy3, din_rdy2, din_rdy1, din_rdy0};

  router_merge #(.DATA_WIDTH(32)) dut (
    .clk(clk), .resetn(resetn),
    .din0(din0), .din1(din1), .din2(din2), .din3(din3),
    .din_en0(din_en0), .din_en1(din_en1), .din_en2(din_en2), .din_en3(din_en3),
    .din_rdy0(din_rdy0), .din_rdy1(din_rdy1), .din_rdy2(din_rdy2), .din_rdy3(din_rdy3),
    .dout(dout), .dout_addr(dout_addr), .dout_valid(dout_valid),
    .dout_ready(dout_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    {din_en0, din_en1, din_en2, din_en3} = 4'b0;
    din0 = '0; din1 = '0; din2 = '0; din3 = '0;
    dout_ready = 1'b1;
    tick();
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dout_valid !== 1'b0 || dout !== 32'h0 || dout_addr !== 2'd0) begin
      errors++;
      $display("FAIL reset_out: valid=%b dout=%h addr=%0d expected 0/0/0", dout_valid, dout, dout_addr);
    end
    checks++;
    if (rdy !== 4'b1111) begin
      errors++;
      $display("FAIL reset_rdy: rdy=%b expected 1111", rdy);
    end
  endtask

  task automatic test_single();
    do_reset();
    din0 = 32'hA5A5_0001; din_en0 = 1'b1;
    tick();
    din_en0 = 1'b0; din0 = 32'hDEAD_BEEF;
    checks++;
    if (dout_valid !== 1'b0 || din_rdy0 !== 1'b0) begin
      errors++;
      $display("FAIL single_buffered: valid=%b rdy0=%b expected 0/0", dout_valid, din_rdy0);
    end
    tick();
    checks++;
    if (dout_valid !== 1'b1 || dout !== 32'hA5A5_0001 || dout_addr !== 2'd0) begin
      errors++;
      $display("FAIL single_out: valid=%b dout=%h addr=%0d expected 1/a5a50001/0", dout_valid, dout, dout_addr);
    end
    tick();
    checks++;
    if (dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_once: valid=%b expected 0", dout_valid);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    din0 = 32'h10; din1 = 32'h11; din2 = 32'h12; din3 = 32'h13;
    {din_en0, din_en1, din_en2, din_en3} = 4'b1111;
    tick();
    {din_en0, din_en1, din_en2, din_en3} = 4'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (dout_valid !== 1'b1 || dout_addr !== 2'(i) || dout !== 32'h10 + 32'(i)) begin
        errors++;
        $display("FAIL b2b_%0d: valid=%b addr=%0d dout=%h expected 1/%0d/%h", i, dout_valid, dout_addr, dout, i, 32'h10 + 32'(i));
      end
    end
    tick();
    checks++;
    if (dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: valid=%b expected 0", dout_valid);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    dout_ready = 1'b0;
    din1 = 32'h21; din_en1 = 1'b1;
    din2 = 32'h22; din_en2 = 1'b1;
    tick();
    din1 = 32'h23; din_en2 = 1'b0;
    tick();
    tick();
    din_en1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dout_valid !== 1'b1 || dout !== 32'h21 || dout_addr !== 2'd1 || din_rdy1 !== 1'b0 || din_rdy2 !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d: valid=%b dout=%h addr=%0d rdy1=%b rdy2=%b expected 1/21/1/0/0",
                 i, dout_valid, dout, dout_addr, din_rdy1, din_rdy2);
      end
      tick();
    end
    dout_ready = 1'b1;
    tick();
    checks++;
    if (dout_valid !== 1'b1 || dout !== 32'h22 || dout_addr !== 2'd2) begin
      errors++;
      $display("FAIL release_p2: valid=%b dout=%h addr=%0d expected 1/22/2", dout_valid, dout, dout_addr);
    end
    tick();
    checks++;
    if (dout_valid !== 1'b1 || dout !== 32'h23 || dout_addr !== 2'd1) begin
      errors++;
      $display("FAIL release_p1: valid=%b dout=%h addr=%0d expected 1/23/1", dout_valid, dout, dout_addr);
    end
  endtask

  task automatic test_fairness();
    int unsigned seq0 = 0, seq3 = 0, exp0 = 0, exp3 = 0;
    logic [1:0]  prev = 2'd3;
    logic        acc0, acc3;
    logic [31:0] want;
    do_reset();
    for (int c = 0; c < 26; c++) begin
      din_en0 = (c < 20);
      din_en3 = (c < 20);
      din0 = 32'h0000_0000 | seq0;
      din3 = 32'h3000_0000 | seq3;
      acc0 = din_en0 && din_rdy0;
      acc3 = din_en3 && din_rdy3;
      tick();
      if (acc0) seq0++;
      if (acc3) seq3++;
      if (dout_valid) begin
        checks++;
        if (dout_addr !== ((prev == 2'd0) ? 2'd3 : 2'd0)) begin
          errors++;
          $display("FAIL alt_addr_c%0d: addr=%0d expected %0d", c, dout_addr, (prev == 2'd0) ? 3 : 0);
        end
        want = (dout_addr == 2'd0) ? (32'h0000_0000 | exp0) : (32'h3000_0000 | exp3);
        checks++;
        if (dout !== want) begin
          errors++;
          $display("FAIL alt_data_c%0d: dout=%h expected %h", c, dout, want);
        end
        if (dout_addr == 2'd0) exp0++; else exp3++;
        prev = dout_addr;
      end
    end
    checks++;
    if (exp0 != seq0 || exp3 != seq3 || seq0 < 5) begin
      errors++;
      $display("FAIL alt_count: out0=%0d out3=%0d expected in0=%0d in3=%0d (>=5)", exp0, exp3, seq0, seq3);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    dout_ready = 1'b0;
    din0 = 32'h50; din1 = 32'h51; din2 = 32'h52;
    {din_en0, din_en1, din_en2} = 3'b111;
    tick();
    din0 = 32'h53; din_en1 = 1'b0; din_en2 = 1'b0;
    tick();
    tick();
    din_en0 = 1'b0;
    checks++;
    if (dout_valid !== 1'b1 || dout !== 32'h50 || rdy !== 4'b1000) begin
      errors++;
      $display("FAIL mid_setup: valid=%b dout=%h rdy=%b expected 1/50/1000", dout_valid, dout, rdy);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (dout_valid !== 1'b0 || rdy !== 4'b1111) begin
      errors++;
      $display("FAIL mid_async: valid=%b rdy=%b expected 0/1111", dout_valid, rdy);
    end
    tick();
    resetn = 1'b1;
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (dout_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_stale_%0d: valid=%b dout=%h expected valid 0", i, dout_valid, dout);
      end
    end
    din0 = 32'h60; din3 = 32'h63;
    din_en0 = 1'b1; din_en3 = 1'b1;
    tick();
    din_en0 = 1'b0; din_en3 = 1'b0;
    tick();
    checks++;
    if (dout_valid !== 1'b1 || dout_addr !== 2'd0 || dout !== 32'h60) begin
      errors++;
      $display("FAIL mid_restart0: valid=%b addr=%0d dout=%h expected 1/0/60", dout_valid, dout_addr, dout);
    end
    tick();
    checks++;
    if (dout_valid !== 1'b1 || dout_addr !== 2'd3 || dout !== 32'h63) begin
      errors++;
      $display("FAIL mid_restart3: valid=%b addr=%0d dout=%h expected 1/3/63", dout_valid, dout_addr, dout);
    end
  endtask

  task automatic test_hold_source();
    do_reset();
    dout_ready = 1'b0;
    din0 = 32'h70; din2 = 32'h72;
    din_en0 = 1'b1; din_en2 = 1'b1;
    tick();
    din_en0 = 1'b0;
    din2 = 32'h80;
    tick();
    din2 = 32'h81;
    tick();
    din2 = 32'h82;
    tick();
    checks++;
    if (din_rdy2 !== 1'b0 || dout !== 32'h70) begin
      errors++;
      $display("FAIL src_blocked: rdy2=%b dout=%h expected 0/70", din_rdy2, dout);
    end
    din2 = 32'h83;
    dout_ready = 1'b1;
    tick();
    checks++;
    if (dout_valid !== 1'b1 || dout_addr !== 2'd2 || dout !== 32'h72) begin
      errors++;
      $display("FAIL src_first: valid=%b addr=%0d dout=%h expected 1/2/72", dout_valid, dout_addr, dout);
    end
    din2 = 32'h84;
    tick();
    din_en2 = 1'b0;
    tick();
    checks++;
    if (dout_valid !== 1'b1 || dout_addr !== 2'd2 || dout !== 32'h84) begin
      errors++;
      $display("FAIL src_second: valid=%b addr=%0d dout=%h expected 1/2/84", dout_valid, dout_addr, dout);
    end
    tick();
    checks++;
    if (dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL src_drain: valid=%b dout=%h expected valid 0", dout_valid, dout);
    end
  endtask

  initial begin
    resetn = 1'b0;
    dout_ready = 1'b1;
    {din_en0, din_en1, din_en2, din_en3} = 4'b0;
    din0 = '0; din1 = '0; din2 = '0; din3 = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_fairness();
    test_reset_mid();
    test_hold_source();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
